// File: rtl/traffic_request_scheduler_if.sv
// traffic_request_scheduler_if: intersection inputs, controller light feedback and request outputs.
// Rev 1.0
`default_nettype none

interface traffic_request_scheduler_if;
  logic       sense_ns;
  logic       sense_ew;
  logic       ped_btn;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [1:0] light_ped;
  logic       car_ns;
  logic       car_ew;
  logic       ped;
  logic       ped_wait;
  logic       forced;

  modport master (
    output sense_ns, sense_ew, ped_btn, light_ns, light_ew, light_ped,
    input  car_ns, car_ew, ped, ped_wait, forced
  );

  modport slave (
    input  sense_ns, sense_ew, ped_btn, light_ns, light_ew, light_ped,
    output car_ns, car_ew, ped, ped_wait, forced
  );
endinterface

`default_nettype wire

// File: rtl/traffic_request_scheduler.sv
// traffic_request_scheduler: qualifies car sensors and ped button into held requests for the light controller.
// Rev 1.0
`default_nettype none

module traffic_request_scheduler #(
  parameter int DEBOUNCE   = 4,
  parameter int PED_PERIOD = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  traffic_request_scheduler_if.slave   bus
);

  localparam int         N_DIR     = 2;
  localparam logic [2:0] GREEN     = 3'b100;
  localparam logic [1:0] WALK      = 2'b11;
  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam bit         DB_SINGLE = (DEBOUNCE == 1);
  localparam logic [2:0] PED_MAX   = 3'(PED_PERIOD);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_QUAL = 2'd1,
    C_PEND = 2'd2,
    C_SERV = 2'd3
  } car_state_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_PEND = 2'd1,
    P_SERV = 2'd2
  } ped_state_t;

  logic [N_DIR-1:0] sense_raw;
  logic [N_DIR-1:0] car_green;
  logic [N_DIR-1:0] car_s1;
  logic [N_DIR-1:0] car_s2;
  logic [N_DIR-1:0] car_req;
  logic             btn_s1;
  logic             btn_s2;
  logic             btn_s3;
  logic             press;
  logic             walk;
  logic             green_any;
  logic             g_prev;
  logic [2:0]       green_cnt;
  logic             at_limit;
  ped_state_t       ped_state;
  ped_state_t       ped_state_nxt;

  assign sense_raw = {bus.sense_ew, bus.sense_ns};
  assign car_green = {bus.light_ew == GREEN, bus.light_ns == GREEN};
  assign green_any = |car_green;
  assign walk      = (bus.light_ped == WALK);
  assign press     = btn_s2 & ~btn_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_s1 <= '0;
      car_s2 <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      car_s1 <= sense_raw;
      car_s2 <= car_s1;
      btn_s1 <= bus.ped_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  generate
    for (genvar d = 0; d < N_DIR; d++) begin : g_car
      car_state_t state;
      car_state_t state_nxt;
      logic [3:0] cnt;
      logic [3:0] cnt_nxt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= C_IDLE;
          cnt   <= 4'd0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // cnt holds the number of high samples already seen; the current one completes the run.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
          C_IDLE: begin
            if (car_s2[d]) begin
              if (DB_SINGLE) begin
                state_nxt = C_PEND;
              end else begin
                state_nxt = C_QUAL;
                cnt_nxt   = 4'd1;
              end
            end
          end
          C_QUAL: begin
            if (!car_s2[d]) begin
              state_nxt = C_IDLE;
              cnt_nxt   = 4'd0;
            end else if (cnt == DB_LAST) begin
              state_nxt = C_PEND;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end
          C_PEND: begin
            if (car_green[d]) state_nxt = C_SERV;
          end
          C_SERV: begin
            if (!car_green[d]) state_nxt = C_IDLE;
          end
          default: begin
            state_nxt = C_IDLE;
            cnt_nxt   = 4'd0;
          end
        endcase
      end

      assign car_req[d] = (state == C_PEND);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ped_state <= P_IDLE;
    else        ped_state <= ped_state_nxt;
  end

  always_comb begin
    ped_state_nxt = ped_state;
    case (ped_state)
      P_IDLE: if (press) ped_state_nxt = P_PEND;
      P_PEND: if (walk)  ped_state_nxt = P_SERV;
      P_SERV: if (!walk) ped_state_nxt = press ? P_PEND : P_IDLE;
      default:           ped_state_nxt = P_IDLE;
    endcase
  end

  // A walk phase always resets the starvation count, even on the edge a new green starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev    <= 1'b0;
      green_cnt <= 3'd0;
    end else begin
      g_prev <= green_any;
      if (walk)
        green_cnt <= 3'd0;
      else if (green_any && !g_prev && green_cnt != PED_MAX)
        green_cnt <= green_cnt + 3'd1;
    end
  end

  assign at_limit     = (green_cnt == PED_MAX);
  assign bus.car_ns   = car_req[0];
  assign bus.car_ew   = car_req[1];
  assign bus.ped_wait = (ped_state == P_PEND);
  assign bus.ped      = (ped_state == P_PEND) | at_limit;
  assign bus.forced   = at_limit & (ped_state != P_PEND);

endmodule

`default_nettype wire
